// File: rtl/gb_irq_pkg.sv
// ---------------------------------------------------------------------------
// gb_irq_pkg
// Shared definitions for the Game Boy interrupt controller:
//   - interrupt source bit indices (IF/IE bit positions)
//   - memory-mapped register addresses of IF and IE
//   - default vector base / stride
//   - dispatch state machine encoding
//   - helper that turns a source index into its vector address
// ---------------------------------------------------------------------------
package gb_irq_pkg;

    // Source bit positions in IF / IE
    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    // CPU-visible register addresses
    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    // Vector table layout: source i jumps to VEC_BASE + VEC_STRIDE*i
    localparam logic [7:0] VEC_BASE_DEF   = 8'h40;
    localparam int         VEC_STRIDE_DEF = 8;

    // Dispatch state machine
    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } irq_state_e;

    // 8-bit vector address of a source; wraps modulo 256 like the CPU bus
    function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                            input int         stride,
                                            input int         idx);
        return base + 8'(stride * idx);
    endfunction

endpackage

// File: rtl/gb_irq_prio_enc.sv
// ---------------------------------------------------------------------------
// gb_irq_prio_enc
// Combinational find-first-set: reports the lowest set bit of req_i, which
// is the highest-priority interrupt. Shared by the dispatch path and the
// HALT wake logic.
// Ports:
//   req_i   [N-1:0]      request vector (pending = IF & IE)
//   idx_o   [IDX_W-1:0]  index of the lowest set bit (0 when none)
//   valid_o              at least one bit of req_i is set
// ---------------------------------------------------------------------------
module gb_irq_prio_enc #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set index is the last assignment.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// gb_irq_ctrl
// Game Boy interrupt controller. Rising edges on the source lines latch into
// IF; IF is masked by IE and the master enable IME; the lowest pending index
// is offered to the CPU with its vector. On dispatch the taken IF bit is
// cleared, IME is dropped and the source gets a one-cycle ack pulse.
// Ports:
//   clk_i          system clock (rising edge)
//   reset_i        asynchronous active-high reset
//   irq_src_i      request lines (0 vblank, 1 stat, 2 timer, 3 serial, 4 joypad)
//   sel_if_i       register access targets IF
//   sel_ie_i       register access targets IE
//   wr_i           write strobe for the selected register
//   wdata_i        write data
//   rdata_o        registered read data
//   ime_set_i      EI/RETI pulse (delayed enable)
//   ime_clr_i      DI pulse
//   int_take_i     CPU begins dispatch
//   int_done_i     CPU has fetched the vector
//   int_req_o      dispatch request
//   int_vec_o      latched vector address
//   int_active_o   dispatch in progress
//   wake_o         HALT wake, ignores IME
//   src_ack_o      one-cycle ack pulse per source
// ---------------------------------------------------------------------------
module gb_irq_ctrl
    import gb_irq_pkg::*;
#(
    parameter int         NUM_SRC    = 5,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int         VEC_STRIDE = VEC_STRIDE_DEF,
    parameter int         EI_DELAY   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               sel_if_i,
    input  logic               sel_ie_i,
    input  logic               wr_i,
    input  logic [7:0]         wdata_i,
    output logic [7:0]         rdata_o,
    input  logic               ime_set_i,
    input  logic               ime_clr_i,
    input  logic               int_take_i,
    input  logic               int_done_i,
    output logic               int_req_o,
    output logic [7:0]         int_vec_o,
    output logic               int_active_o,
    output logic               wake_o,
    output logic [NUM_SRC-1:0] src_ack_o
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] if_q, if_d;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [7:0]         ie_q, ie_d;
    logic [7:0]         rdata_q, rdata_d;
    logic [7:0]         vec_q, vec_d;
    logic               ime_q, ime_d;
    logic [EI_DELAY-1:0] ei_q, ei_d;

    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] disp_clr;
    logic [NUM_SRC-1:0] pending;
    logic [IDX_W-1:0]   pend_idx;
    logic               pend_valid;
    logic               dispatch;
    logic               if_wr;
    logic               ie_wr;
    logic [7:0]         if_read;

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    assign edge_set = irq_src_i & ~prev_q;
    assign pending  = if_q & ie_q[NUM_SRC-1:0];
    assign if_wr    = wr_i & sel_if_i;
    assign ie_wr    = wr_i & sel_ie_i;

    gb_irq_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req_i   (pending),
        .idx_o   (pend_idx),
        .valid_o (pend_valid)
    );

    // A take is honoured only while idle with IME set; with nothing pending
    // it still enters SERVE (cancelled request) but clears no IF bit.
    assign dispatch = (state_q == IDLE) && ime_q && int_take_i;

    // Per-bit IF update: a fresh source edge beats the dispatch clear, which
    // beats a CPU write. The same one-hot drives the ack pulse.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_if_bit
        assign disp_clr[gi] = dispatch && pend_valid && (pend_idx == IDX_W'(gi));
        assign if_d[gi]     = edge_set[gi] ? 1'b1 :
                              disp_clr[gi] ? 1'b0 :
                              if_wr        ? wdata_i[gi] :
                                             if_q[gi];
    end

    assign ack_d = disp_clr;
    assign ie_d  = ie_wr ? wdata_i : ie_q;

    // Unimplemented IF bits read back as 1
    always_comb begin
        if_read              = 8'hFF;
        if_read[NUM_SRC-1:0] = if_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (!wr_i && sel_if_i) begin
            rdata_d = if_read;
        end else if (!wr_i && sel_ie_i) begin
            rdata_d = ie_q;
        end
    end

    // ------------------------------------------------------------------
    // IME with delayed enable: ime_set enters a shift pipeline and IME
    // rises when it falls out the end. DI or a dispatch flushes everything
    // and wins over a simultaneous EI.
    // ------------------------------------------------------------------
    always_comb begin
        ime_d = ime_q;
        ei_d  = ei_q;
        if (ime_clr_i || dispatch) begin
            ime_d = 1'b0;
            ei_d  = '0;
        end else begin
            ime_d = ime_q | ei_q[EI_DELAY-1];
            ei_d  = EI_DELAY'({ei_q, ime_set_i});
        end
    end

    always_comb begin
        vec_d = vec_q;
        if (dispatch) begin
            vec_d = pend_valid ? vec_addr(VEC_BASE, VEC_STRIDE, int'(pend_idx)) : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dispatch)   state_d = SERVE;
            SERVE:   if (int_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int_req_o    = 1'b0;
        int_active_o = 1'b0;
        unique case (state_q)
            IDLE:    int_req_o    = ime_q && pend_valid;
            SERVE:   int_active_o = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            if_q    <= '0;
            prev_q  <= '0;
            ack_q   <= '0;
            ie_q    <= '0;
            rdata_q <= '0;
            vec_q   <= '0;
            ime_q   <= 1'b0;
            ei_q    <= '0;
        end else begin
            if_q    <= if_d;
            prev_q  <= irq_src_i;
            ack_q   <= ack_d;
            ie_q    <= ie_d;
            rdata_q <= rdata_d;
            vec_q   <= vec_d;
            ime_q   <= ime_d;
            ei_q    <= ei_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign int_vec_o = vec_q;
    assign wake_o    = pend_valid;
    assign src_ack_o = ack_q;

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gb_irq_ctrl
// Directed scenarios followed by a randomized run, all checked against a
// cycle-level reference model written from the controller's rules
// (IF/IE bytes, an IME countdown, a serve flag) plus constant expectations
// for the directed scenarios.
// ---------------------------------------------------------------------------
module tb_gb_irq_ctrl;

    localparam int EI_DELAY = 1;

    logic       clk;
    logic       reset;
    logic [4:0] irq_src;
    logic       sel_if, sel_ie, wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ime_set, ime_clr, int_take, int_done;
    logic       int_req;
    logic [7:0] int_vec;
    logic       int_active;
    logic       wake;
    logic [4:0] src_ack;

    int checks = 0;
    int errors = 0;

    gb_irq_ctrl dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .irq_src_i    (irq_src),
        .sel_if_i     (sel_if),
        .sel_ie_i     (sel_ie),
        .wr_i         (wr),
        .wdata_i      (wdata),
        .rdata_o      (rdata),
        .ime_set_i    (ime_set),
        .ime_clr_i    (ime_clr),
        .int_take_i   (int_take),
        .int_done_i   (int_done),
        .int_req_o    (int_req),
        .int_vec_o    (int_vec),
        .int_active_o (int_active),
        .wake_o       (wake),
        .src_ack_o    (src_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [4:0] m_if, m_prev, m_ack;
    logic [7:0] m_ie, m_rdata, m_vec;
    logic       m_ime, m_serve;
    int         m_ei;     // edges remaining until IME rises (0 = none queued)

    task automatic model_reset();
        m_if = 0; m_prev = 0; m_ack = 0; m_ie = 0; m_rdata = 0; m_vec = 0;
        m_ime = 0; m_serve = 0; m_ei = 0;
    endtask

    // Apply one rising edge with the inputs currently driven.
    task automatic model_step();
        logic [4:0] rise, pend, clr;
        logic       take;
        int         idx;
        rise = irq_src & ~m_prev;
        pend = m_if & m_ie[4:0];
        take = !m_serve && m_ime && int_take;
        clr  = 0;
        if (take) begin
            if (pend != 0) begin
                idx = 0;
                for (int i = 4; i >= 0; i--) if (pend[i]) idx = i;
                m_vec = 8'(8'h40 + 8 * idx);
                clr   = 5'(1 << idx);
            end else begin
                m_vec = 8'h00;
            end
            m_serve = 1'b1;
        end else if (m_serve && int_done) begin
            m_serve = 1'b0;
        end
        m_ack = clr;
        if (!wr && sel_if)      m_rdata = 8'hE0 | {3'b000, m_if};
        else if (!wr && sel_ie) m_rdata = m_ie;
        m_if = (((wr && sel_if) ? wdata[4:0] : m_if) & ~clr) | rise;
        if (wr && sel_ie) m_ie = wdata;
        if (ime_clr || take) begin
            m_ime = 1'b0;
            m_ei  = 0;
        end else begin
            if (m_ei == 1) m_ime = 1'b1;
            if (m_ei > 0)  m_ei--;
            if (ime_set)   m_ei = EI_DELAY;
        end
        m_prev = irq_src;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [4:0] pend;
        pend = m_if & m_ie[4:0];
        chk({tag, ".int_req"},    8'(int_req),    8'(m_ime && pend != 0 && !m_serve));
        chk({tag, ".wake"},       8'(wake),       8'(pend != 0));
        chk({tag, ".int_active"}, 8'(int_active), 8'(m_serve));
        chk({tag, ".int_vec"},    int_vec,        m_vec);
        chk({tag, ".src_ack"},    8'(src_ack),    8'(m_ack));
        chk({tag, ".rdata"},      rdata,          m_rdata);
    endtask

    // One clock: edge, model, sample 1 time unit later, drop one-shot inputs.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
        wr = 0; sel_if = 0; sel_ie = 0; ime_set = 0; ime_clr = 0;
        int_take = 0; int_done = 0;
    endtask

    task automatic write_reg(input logic is_ie, input logic [7:0] d);
        sel_if = !is_ie; sel_ie = is_ie; wr = 1; wdata = d;
        cyc("write");
        $display("txn write %s <= %h", is_ie ? "IE" : "IF", d);
    endtask

    task automatic read_reg(input logic is_ie, input logic [7:0] exp);
        sel_if = !is_ie; sel_ie = is_ie; wr = 0;
        cyc("read");
        chk(is_ie ? "read_ie" : "read_if", rdata, exp);
        $display("txn read %s -> %h", is_ie ? "IE" : "IF", rdata);
    endtask

    task automatic take_int(input logic [7:0] exp_vec, input logic [4:0] exp_ack);
        int_take = 1;
        cyc("take");
        chk("take_vec", int_vec, exp_vec);
        chk("take_ack", 8'(src_ack), 8'(exp_ack));
        chk("take_active", 8'(int_active), 8'h01);
        $display("txn take vec=%h ack=%b", int_vec, src_ack);
    endtask

    task automatic done_int();
        int_done = 1;
        cyc("done");
        chk("done_active", 8'(int_active), 8'h00);
        $display("txn done");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1; irq_src = 0; sel_if = 0; sel_ie = 0; wr = 0; wdata = 0;
        ime_set = 0; ime_clr = 0; int_take = 0; int_done = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int_req", 8'(int_req), 8'h00);
        chk("rst_active", 8'(int_active), 8'h00);
        chk("rst_vec", int_vec, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ack", 8'(src_ack), 8'h00);
        @(negedge clk);
        reset = 0;
        read_reg(0, 8'hE0);

        // Timer request end to end
        write_reg(1, 8'h04);
        ime_set = 1; cyc("ei");
        irq_src = 5'h04; cyc("timer_edge");
        chk("t1_int_req", 8'(int_req), 8'h01);
        read_reg(0, 8'hE4);
        irq_src = 0;
        take_int(8'h50, 5'h04);
        cyc("after_take");
        chk("t1_ack_one_cycle", 8'(src_ack), 8'h00);
        read_reg(0, 8'hE0);
        chk("t1_ime_cleared", 8'(int_req), 8'h00);
        done_int();

        // Priority: stat beats joypad, then joypad after RETI
        write_reg(1, 8'h1F);
        ime_set = 1; cyc("ei");
        cyc("idle");
        irq_src = 5'h12; cyc("two_edges");
        take_int(8'h48, 5'h02);
        done_int();
        ime_set = 1; cyc("reti");
        cyc("idle");
        chk("t2_second_req", 8'(int_req), 8'h01);
        take_int(8'h60, 5'h10);
        done_int();
        irq_src = 0;

        // Wake without IME; held line does not re-set IF
        write_reg(1, 8'h01);
        irq_src = 5'h01; cyc("vblank_edge");
        chk("t3_wake", 8'(wake), 8'h01);
        chk("t3_no_req", 8'(int_req), 8'h00);
        write_reg(0, 8'h00);
        repeat (10) cyc("held_high");
        chk("t3_wake_clear", 8'(wake), 8'h00);
        read_reg(0, 8'hE0);
        irq_src = 0;

        // Cancelled request: IE cleared before take
        write_reg(1, 8'h04);
        ime_set = 1; cyc("ei");
        cyc("idle");
        irq_src = 5'h04; cyc("timer_edge");
        chk("t4_req", 8'(int_req), 8'h01);
        irq_src = 0;
        write_reg(1, 8'h00);
        take_int(8'h00, 5'h00);
        read_reg(0, 8'hE4);
        done_int();

        // Same-cycle precedence
        irq_src = 5'h08;
        write_reg(0, 8'h00);
        read_reg(0, 8'hE8);
        irq_src = 0;
        ime_set = 1; ime_clr = 1; cyc("ei_and_di");
        cyc("idle");
        cyc("idle");
        write_reg(1, 8'h08);
        chk("t5_wake", 8'(wake), 8'h01);
        chk("t5_ime_stays_0", 8'(int_req), 8'h00);

        // Asynchronous reset in the middle of SERVE
        ime_set = 1; cyc("ei");
        cyc("idle");
        chk("t6_req", 8'(int_req), 8'h01);
        take_int(8'h58, 5'h08);
        #3;
        reset = 1;
        #1;
        chk("arst_active", 8'(int_active), 8'h00);
        chk("arst_vec", int_vec, 8'h00);
        chk("arst_ack", 8'(src_ack), 8'h00);
        chk("arst_wake", 8'(wake), 8'h00);
        chk("arst_req", 8'(int_req), 8'h00);
        model_reset();
        @(negedge clk);
        reset = 0;
        read_reg(0, 8'hE0);
        read_reg(1, 8'h00);
        cyc("post_reset");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4:0] pend;
            pend = m_if & m_ie[4:0];
            if ($urandom_range(0, 3) == 0) irq_src = 5'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                sel_if = 1'($urandom); sel_ie = 1'($urandom);
                wr = 1'($urandom); wdata = 8'($urandom);
            end
            ime_set = ($urandom_range(0, 5) == 0);
            ime_clr = ($urandom_range(0, 15) == 0);
            if (m_ime && pend != 0 && !m_serve) int_take = ($urandom_range(0, 1) == 0);
            else                                int_take = ($urandom_range(0, 9) == 0);
            int_done = m_serve ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            if (int_take && m_ime && !m_serve)
                $display("txn random take at step %0d pending=%b", n, pend);
            cyc("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
